branch_trace_sequencer: RTL and testbench

Upstream driver for the perceptron branch predictor core. Buffers incoming branch records (instruction low byte + resolved direction) in a small FIFO and replays them one at a time through the predictor's new-data / prediction-ready / training-done handshake. Captures each prediction and keeps branch and mispredict counts. Includes a watchdog that drops a record if the predictor stalls. Sits between the trace source (test harness or host interface) and the predictor's `inst_lowest_byte` / `new_data_avail` / `direction_ground_truth` inputs.

---
 rtl/branch_trace_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_branch_trace_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_trace_sequencer.sv
// branch_trace_sequencer: buffers branch trace records in a FIFO and replays
// them one at a time through the perceptron predictor handshake
// (new_data_avail -> pred_ready -> training_done), with a per-phase watchdog.
//
// Optional feature macro: SEQ_STATS_EN. When defined, branch_count,
// mispredict_count, last_pred and last_pred_valid are live. When undefined,
// they are tied to 0 and their registers are removed.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        trace record handshake (in_addr, in_taken)
//   mem_reset_done           predictor weight memory initialised
//   pred_ready, prediction   predictor prediction strobe and direction
//   training_done            predictor weight update finished
//   inst_lowest_byte,
//   direction_ground_truth,
//   new_data_avail           registered request to the predictor
//   last_pred(_valid)        most recent captured prediction
//   busy                     FSM not idle or FIFO non-empty
//   timeout_err              sticky watchdog flag
//   branch_count,
//   mispredict_count         saturating statistics counters
module branch_trace_sequencer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_addr,
    input  logic             in_taken,
    input  logic             mem_reset_done,
    input  logic             pred_ready,
    input  logic             prediction,
    input  logic             training_done,
    output logic [7:0]       inst_lowest_byte,
    output logic             direction_ground_truth,
    output logic             new_data_avail,
    output logic             last_pred,
    output logic             last_pred_valid,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT);
    localparam int unsigned REC_W = 9;

    typedef enum logic [2:0] {
        WAIT_MEM,
        IDLE,
        ISSUE,
        TRAIN,
        GAP
    } state_t;

    state_t            state;
    logic [WD_W-1:0]   wd;
    logic              wd_hit;

    logic [REC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // FIFO flags; in_ready ignores a same-cycle pop so a full FIFO never takes a push
    assign full     = (occ == OCC_W'(DEPTH));
    assign empty    = (occ == '0);
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !empty;
    assign busy     = !rst && ((state != IDLE) || !empty);
    assign wd_hit   = (wd == WD_W'(TIMEOUT - 1));

    // Record storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_addr, in_taken};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Handshake sequencer with per-phase watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= WAIT_MEM;
            wd                     <= '0;
            inst_lowest_byte       <= '0;
            direction_ground_truth <= 1'b0;
            new_data_avail         <= 1'b0;
            timeout_err            <= 1'b0;
        end else begin
            case (state)
                WAIT_MEM: begin
                    if (mem_reset_done) state <= IDLE;
                end
                IDLE: begin
                    if (!empty) begin
                        {inst_lowest_byte, direction_ground_truth} <= mem[rd_ptr];
                        new_data_avail <= 1'b1;
                        wd             <= '0;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (pred_ready) begin
                        wd <= '0;
                        if (training_done) begin
                            new_data_avail <= 1'b0;
                            state          <= GAP;
                        end else begin
                            state <= TRAIN;
                        end
                    end else if (wd_hit) begin
                        timeout_err    <= 1'b1;
                        new_data_avail <= 1'b0;
                        wd             <= '0;
                        state          <= GAP;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                TRAIN: begin
                    if (training_done) begin
                        new_data_avail <= 1'b0;
                        wd             <= '0;
                        state          <= GAP;
                    end else if (wd_hit) begin
                        timeout_err    <= 1'b1;
                        new_data_avail <= 1'b0;
                        wd             <= '0;
                        state          <= GAP;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                GAP: begin
                    // guarantees new_data_avail is low for a full cycle
                    state <= IDLE;
                end
                default: begin
                    state <= WAIT_MEM;
                end
            endcase
        end
    end

`ifdef SEQ_STATS_EN
    logic capture;
    logic complete;

    // An event in its awaiting state wins over a watchdog expiry on the same edge
    assign capture  = (state == ISSUE) && pred_ready;
    assign complete = training_done &&
                      (((state == ISSUE) && pred_ready) || (state == TRAIN));

    // Prediction capture and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pred        <= 1'b0;
            last_pred_valid  <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (capture) begin
                last_pred       <= prediction;
                last_pred_valid <= 1'b1;
                if ((prediction != direction_ground_truth) && (mispredict_count != '1)) begin
                    mispredict_count <= mispredict_count + CNT_W'(1);
                end
            end
            if (complete && (branch_count != '1)) begin
                branch_count <= branch_count + CNT_W'(1);
            end
        end
    end
`else
    // prediction only feeds the statistics, which are absent in this build
    logic unused_stats;
    assign unused_stats     = prediction;
    assign last_pred        = 1'b0;
    assign last_pred_valid  = 1'b0;
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_trace_sequencer.sv
// Self-checking bench for branch_trace_sequencer. The bench plays the role of
// the predictor and keeps a record queue plus expected statistics.
module tb_branch_trace_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 8;
`ifdef SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_addr;
    logic             in_taken;
    logic             mem_reset_done;
    logic             pred_ready;
    logic             prediction;
    logic             training_done;
    logic [7:0]       inst_lowest_byte;
    logic             direction_ground_truth;
    logic             new_data_avail;
    logic             last_pred;
    logic             last_pred_valid;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    branch_trace_sequencer #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_taken(in_taken), .mem_reset_done(mem_reset_done),
        .pred_ready(pred_ready), .prediction(prediction), .training_done(training_done),
        .inst_lowest_byte(inst_lowest_byte), .direction_ground_truth(direction_ground_truth),
        .new_data_avail(new_data_avail), .last_pred(last_pred),
        .last_pred_valid(last_pred_valid), .busy(busy), .timeout_err(timeout_err),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending records in order, plus expected statistics
    logic [8:0] exp_q[$];
    int         m_branch;
    int         m_mis;
    bit         m_lp;
    bit         m_lpv;
    bit         m_to;

    // Cycles the current request has already been held high before now
    int nda_age;
    always @(posedge clk) nda_age <= new_data_avail ? nda_age + 1 : 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_branch = 0;
        m_mis    = 0;
        m_lp     = 1'b0;
        m_lpv    = 1'b0;
        m_to     = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input bit t);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL push_ready: in_ready=%b, required 1", in_ready);
        end
        in_valid = 1'b1;
        in_addr  = a;
        in_taken = t;
        tick();
        in_valid = 1'b0;
        exp_q.push_back({a, t});
    endtask

    // One record: wait for issue, answer after pl cycles (pl>=TIMEOUT: never),
    // then finish training tl cycles later (0: same cycle, >TIMEOUT: never)
    task automatic do_record(input int pl, input bit pv, input int tl,
                             input bit noise, input string tag);
        int         n;
        int         wait_n;
        logic [8:0] rec;
        n = 0;
        while (new_data_avail !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (new_data_avail !== 1'b1 || exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s issue: new_data_avail=%b queued=%0d, required 1 with a queued record",
                     tag, new_data_avail, exp_q.size());
            return;
        end
        rec = exp_q.pop_front();
        n_cmp++;
        if ({inst_lowest_byte, direction_ground_truth} !== rec) begin
            n_bad++;
            $display("FAIL %s record: got %h/%b, required %h/%b", tag,
                     inst_lowest_byte, direction_ground_truth, rec[8:1], rec[0]);
        end
        if (pl >= int'(TIMEOUT)) begin
            training_done = noise;
            wait_n = int'(TIMEOUT) - nda_age;
            repeat (wait_n) tick();
            training_done = 1'b0;
            m_to = 1'b1;
        end else begin
            wait_n = (pl > nda_age) ? pl - nda_age : 0;
            training_done = noise;
            repeat (wait_n) tick();
            pred_ready    = 1'b1;
            prediction    = pv;
            training_done = (tl == 0);
            tick();
            pred_ready    = 1'b0;
            training_done = 1'b0;
            m_lp  = pv;
            m_lpv = 1'b1;
            if (pv != rec[0]) m_mis++;
            if (tl == 0) begin
                m_branch++;
            end else begin
                repeat ((tl > int'(TIMEOUT) ? int'(TIMEOUT) : tl) - 1) tick();
                n_cmp++;
                if (new_data_avail !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s train_hold: new_data_avail=%b, required 1", tag, new_data_avail);
                end
                if (tl > int'(TIMEOUT)) begin
                    tick();
                    m_to = 1'b1;
                end else begin
                    training_done = 1'b1;
                    tick();
                    training_done = 1'b0;
                    m_branch++;
                end
            end
        end
        n_cmp++;
        if (new_data_avail !== 1'b0) begin
            n_bad++;
            $display("FAIL %s gap: new_data_avail=%b, required 0", tag, new_data_avail);
        end
        n_cmp++;
        if (timeout_err !== m_to) begin
            n_bad++;
            $display("FAIL %s timeout_err: got %b, required %b", tag, timeout_err, m_to);
        end
        n_cmp++;
        if (branch_count !== CNT_W'(STATS ? m_branch : 0)) begin
            n_bad++;
            $display("FAIL %s branch_count: got %0d, required %0d", tag, branch_count, STATS ? m_branch : 0);
        end
        n_cmp++;
        if (mispredict_count !== CNT_W'(STATS ? m_mis : 0)) begin
            n_bad++;
            $display("FAIL %s mispredict_count: got %0d, required %0d", tag, mispredict_count, STATS ? m_mis : 0);
        end
        n_cmp++;
        if ({last_pred_valid, last_pred} !== (STATS ? {m_lpv, m_lp} : 2'b00)) begin
            n_bad++;
            $display("FAIL %s last_pred: got v=%b p=%b, required v=%b p=%b", tag,
                     last_pred_valid, last_pred, STATS & m_lpv, STATS & m_lp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        model_clear();
        n_cmp++;
        if ({in_ready, inst_lowest_byte, direction_ground_truth, new_data_avail, last_pred,
             last_pred_valid, busy, timeout_err, branch_count, mispredict_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b ilb=%h dgt=%b nda=%b lp=%b lpv=%b busy=%b to=%b bc=%0d mc=%0d, required all 0",
                     in_ready, inst_lowest_byte, direction_ground_truth, new_data_avail, last_pred,
                     last_pred_valid, busy, timeout_err, branch_count, mispredict_count);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || new_data_avail !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b nda=%b, required 1/0", in_ready, new_data_avail);
        end
    endtask

    task automatic test_wait_mem();
        for (int i = 0; i < 3; i++) push(8'($urandom), 1'($urandom));
        repeat (3) tick();
        n_cmp++;
        if (new_data_avail !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_mem_hold: nda=%b busy=%b, required 0/1", new_data_avail, busy);
        end
        mem_reset_done = 1'b1;
        tick();
        n_cmp++;
        if (new_data_avail !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_mem_idle: nda=%b, required 0", new_data_avail);
        end
        tick();
        n_cmp++;
        if (new_data_avail !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_mem_issue: nda=%b, required 1", new_data_avail);
        end
        for (int i = 0; i < 3; i++)
            do_record(int'($urandom_range(3, 0)), 1'($urandom), int'($urandom_range(3, 0)), 1'b0, "wait_mem");
    endtask

    task automatic test_directed_a5();
        push(8'hA5, 1'b1);
        do_record(3, 1'b0, 5, 1'b1, "a5");
        tick();
        n_cmp++;
        if (inst_lowest_byte !== 8'hA5 || direction_ground_truth !== 1'b1) begin
            n_bad++;
            $display("FAIL a5_hold: got %h/%b, required a5/1", inst_lowest_byte, direction_ground_truth);
        end
    endtask

    task automatic test_fill();
        int b0;
        b0 = m_branch;
        for (int i = 0; i <= int'(DEPTH); i++) push(8'(8'h10 + i), 1'($urandom));
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_full: in_ready=%b, required 0", in_ready);
        end
        in_valid = 1'b1;
        in_addr  = 8'hEE;
        in_taken = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i <= int'(DEPTH); i++)
            do_record(int'($urandom_range(2, 0)), 1'($urandom), int'($urandom_range(3, 1)), 1'b0, "fill");
        repeat (5) tick();
        n_cmp++;
        if (new_data_avail !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_drained: nda=%b busy=%b, required 0/0", new_data_avail, busy);
        end
        n_cmp++;
        if (branch_count !== CNT_W'(STATS ? b0 + int'(DEPTH) + 1 : 0)) begin
            n_bad++;
            $display("FAIL fill_count: branch_count=%0d, required %0d", branch_count,
                     STATS ? b0 + int'(DEPTH) + 1 : 0);
        end
    endtask

    task automatic test_back_to_back();
        push(8'h3C, 1'b0);
        push(8'hC3, 1'b1);
        do_record(0, 1'b1, 0, 1'b0, "b2b_first");
        tick();
        n_cmp++;
        if (new_data_avail !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap2: nda=%b, required 0", new_data_avail);
        end
        tick();
        n_cmp++;
        if (new_data_avail !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_reissue: nda=%b, required 1", new_data_avail);
        end
        do_record(0, 1'b1, 0, 1'b0, "b2b_second");
    endtask

    task automatic test_timeout();
        push(8'h77, 1'b0);
        push(8'h88, 1'b1);
        do_record(int'(TIMEOUT), 1'b0, 0, 1'b0, "timeout_issue");
        do_record(1, 1'b1, 2, 1'b0, "timeout_next");
        push(8'h99, 1'b0);
        do_record(0, 1'b1, int'(TIMEOUT) + 1, 1'b0, "timeout_train");
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            int sz;
            sz = int'($urandom_range(4, 1));
            for (int i = 0; i < sz; i++) push(8'($urandom), 1'($urandom));
            for (int i = 0; i < sz; i++)
                do_record(int'($urandom_range(TIMEOUT + 1, 0)), 1'($urandom),
                          int'($urandom_range(TIMEOUT + 2, 0)), 1'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 3; i++) push(8'($urandom), 1'($urandom));
        n = 0;
        while (new_data_avail !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        pred_ready = 1'b1;
        prediction = 1'b1;
        tick();
        pred_ready = 1'b0;
        rst = 1'b1;
        tick();
        model_clear();
        n_cmp++;
        if ({in_ready, inst_lowest_byte, direction_ground_truth, new_data_avail, last_pred,
             last_pred_valid, busy, timeout_err, branch_count, mispredict_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: rdy=%b ilb=%h dgt=%b nda=%b lp=%b lpv=%b busy=%b to=%b bc=%0d mc=%0d, required all 0",
                     in_ready, inst_lowest_byte, direction_ground_truth, new_data_avail, last_pred,
                     last_pred_valid, busy, timeout_err, branch_count, mispredict_count);
        end
        rst = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (new_data_avail !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_empty: nda=%b busy=%b, required 0/0", new_data_avail, busy);
        end
        push(8'h5A, 1'b0);
        do_record(1, 1'b1, 1, 1'b0, "reset_mid_recover");
    endtask

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        in_addr        = '0;
        in_taken       = 1'b0;
        mem_reset_done = 1'b0;
        pred_ready     = 1'b0;
        prediction     = 1'b0;
        training_done  = 1'b0;
        test_reset();
        test_wait_mem();
        test_directed_a5();
        test_fill();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
